// File: rtl/toggle_pulse_gen_if.sv
// Button-side bundle of the toggle pulse generator: raw button in,
// debounced level, toggle pulse, busy flag and press counter out.
interface toggle_pulse_gen_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 btn_in;
  logic                 t_out;
  logic                 btn_stable;
  logic                 busy;
  logic [CNT_WIDTH-1:0] press_count;

  modport master (
    output btn_in,
    input  t_out,
    input  btn_stable,
    input  busy,
    input  press_count
  );

  modport slave (
    input  btn_in,
    output t_out,
    output btn_stable,
    output busy,
    output press_count
  );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Synchronises and debounces a raw push-button, emitting one registered
// t_out pulse per accepted press and counting accepted presses.
module toggle_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic           clk,
  input  logic           reset,
  toggle_pulse_gen_if.slave bus
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DCNT_W-1:0]      r_dcnt;
  logic [DCNT_W-1:0]      w_dcnt_nxt;
  logic                   r_t_out;
  logic                   w_t_out_nxt;
  logic                   r_btn_stable;
  logic                   w_btn_stable_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic [CNT_WIDTH-1:0]   r_press_count;
  logic [CNT_WIDTH-1:0]   w_press_count_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_dcnt        <= '0;
      r_t_out       <= 1'b0;
      r_btn_stable  <= 1'b0;
      r_busy        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_dcnt        <= w_dcnt_nxt;
      r_t_out       <= w_t_out_nxt;
      r_btn_stable  <= w_btn_stable_nxt;
      r_busy        <= w_busy_nxt;
      r_press_count <= w_press_count_nxt;
    end
  end

  // Any opposite sample inside a wait window returns to the settled state
  // it came from without a pulse.
  always_comb begin
    w_state_nxt       = r_state;
    w_dcnt_nxt        = r_dcnt;
    w_t_out_nxt       = 1'b0;
    w_btn_stable_nxt  = r_btn_stable;
    w_press_count_nxt = r_press_count;
    case (r_state)
      IDLE: begin
        if (w_sync) begin
          w_state_nxt = PRESS_WAIT;
          w_dcnt_nxt  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_sync) begin
          w_state_nxt = IDLE;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt       = HELD;
          w_t_out_nxt       = 1'b1;
          w_btn_stable_nxt  = 1'b1;
          w_press_count_nxt = r_press_count + CNT_WIDTH'(1);
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_W'(1);
        end
      end
      HELD: begin
        if (!w_sync) begin
          w_state_nxt = RELEASE_WAIT;
          w_dcnt_nxt  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_sync) begin
          w_state_nxt = HELD;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt      = IDLE;
          w_btn_stable_nxt = 1'b0;
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == PRESS_WAIT) || (w_state_nxt == RELEASE_WAIT);
  end

  assign bus.t_out       = r_t_out;
  assign bus.btn_stable  = r_btn_stable;
  assign bus.busy        = r_busy;
  assign bus.press_count = r_press_count;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench for toggle_pulse_gen: stimulus queues expected pulses,
// a negedge monitor pops and checks them against t_out.
module tb_toggle_pulse_gen;

  localparam int SYNC    = 2;
  localparam int DEB     = 4;
  localparam int CW      = 2;
  localparam int LATENCY = SYNC + 1 + DEB;

  typedef struct {
    int            cycle;
    logic [CW-1:0] count;
  } expect_t;

  logic clk;
  logic reset;
  int   cycleCount;
  int   compared;
  int   mismatched;
  logic [CW-1:0] expCount;
  logic tQ;
  logic prevT;
  expect_t expQ[$];

  toggle_pulse_gen_if #(.CNT_WIDTH(CW)) bus ();

  toggle_pulse_gen #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // downstream T flip-flop fed by t_out
  always @(posedge clk or posedge reset) begin
    if (reset) tQ <= 1'b0;
    else if (bus.t_out) tQ <= ~tQ;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared = compared + 1;
    if (actual !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExpect();
    expect_t e;
    expCount = expCount + 1'b1;
    e.cycle  = cycleCount + LATENCY;
    e.count  = expCount;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    checkOutput("queueDrained", expQ.size(), 0);
    bus.btn_in = 1'b0;
    reset      = 1'b1;
    waitEdges(3);
    reset    = 1'b0;
    expCount = '0;
    waitEdges(2);
  endtask

  task automatic applyStimulus(input logic lvl, input int edges);
    bus.btn_in = lvl;
    waitEdges(edges);
  endtask

  // Monitor: every t_out pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      prevT = 1'b0;
    end else begin
      if (bus.t_out) begin
        if (prevT) checkOutput("tOutDoublePulse", 1, 0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", 1, 0);
        end else begin
          expect_t e;
          e = expQ.pop_front();
          checkOutput("pulseCycle", cycleCount, e.cycle);
          checkOutput("pulseCount", bus.press_count, e.count);
          checkOutput("pulseStable", bus.btn_stable, 1);
        end
      end
      prevT = bus.t_out;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    cycleCount = 0;
    expCount   = '0;
    prevT      = 1'b0;
    bus.btn_in = 1'b0;
    reset      = 1'b1;
    waitEdges(2);
    checkOutput("rstTOut", bus.t_out, 0);
    checkOutput("rstStable", bus.btn_stable, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstCount", bus.press_count, 0);
    reset = 1'b0;
    waitEdges(2);

    // clean press: busy after edges 3..6, pulse and stable at edge 7
    bus.btn_in = 1'b1;
    pushExpect();
    for (int e = 1; e <= 8; e++) begin
      waitEdges(1);
      checkOutput($sformatf("cleanBusy%0d", e), bus.busy, (e >= 3 && e <= 6));
      checkOutput($sformatf("cleanStable%0d", e), bus.btn_stable, (e >= 7));
    end
    waitEdges(12);
    checkOutput("cleanCount", bus.press_count, 1);
    bus.btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      waitEdges(1);
      checkOutput($sformatf("releaseStable%0d", e), bus.btn_stable, (e < 7));
    end
    waitEdges(4);
    checkOutput("releaseCount", bus.press_count, 1);

    // bouncy press: 1,0,1,0 then high
    doReset();
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    pushExpect();
    applyStimulus(1'b1, 20);
    checkOutput("bouncyCount", bus.press_count, 1);
    applyStimulus(1'b0, 12);

    // short glitch rejected
    doReset();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 12);
    checkOutput("glitchCount", bus.press_count, 0);
    checkOutput("glitchBusy", bus.busy, 0);
    checkOutput("glitchStable", bus.btn_stable, 0);

    // release bounce while held, then a second press
    doReset();
    bus.btn_in = 1'b1;
    pushExpect();
    waitEdges(15);
    applyStimulus(1'b0, 2);
    bus.btn_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      waitEdges(1);
      checkOutput($sformatf("holdStable%0d", e), bus.btn_stable, 1);
    end
    applyStimulus(1'b0, 12);
    checkOutput("fullRelStable", bus.btn_stable, 0);
    checkOutput("fullRelCount", bus.press_count, 1);
    bus.btn_in = 1'b1;
    pushExpect();
    waitEdges(12);
    checkOutput("repressCount", bus.press_count, 2);
    applyStimulus(1'b0, 12);

    // asynchronous reset mid-debounce, button held through deassertion
    doReset();
    bus.btn_in = 1'b1;
    waitEdges(4);
    checkOutput("preRstBusy", bus.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstTOut", bus.t_out, 0);
    checkOutput("asyncRstStable", bus.btn_stable, 0);
    checkOutput("asyncRstBusy", bus.busy, 0);
    checkOutput("asyncRstCount", bus.press_count, 0);
    waitEdges(3);
    reset    = 1'b0;
    expCount = '0;
    pushExpect();
    waitEdges(12);
    checkOutput("postRstCount", bus.press_count, 1);
    applyStimulus(1'b0, 12);

    // counter wrap and downstream T flip-flop
    doReset();
    for (int p = 0; p < 5; p++) begin
      bus.btn_in = 1'b1;
      pushExpect();
      waitEdges(10);
      checkOutput($sformatf("wrapCount%0d", p), bus.press_count, (p + 1) % 4);
      applyStimulus(1'b0, 10);
    end
    checkOutput("downstreamQ", tQ, 1);
    checkOutput("finalQueueDrained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/toggle_pulse_gen.md
# toggle_pulse_gen

Upstream driver for the T flip-flop stage: converts a raw, asynchronous, bouncing push-button level into a clean single-cycle toggle request `t_out` that connects directly to the T flip-flop's `T` input.
- Synchronises the input.
- Debounces both press and release with a small FSM and counter.
- Emits exactly one `t_out` pulse per accepted press.
- Keeps a wrapping count of accepted presses for debug and readback.

## Interface
- `SYNC_STAGES`, default 2: number of flip-flops in the input synchroniser; legal range ≥2.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive stable synchronised samples required after the first edge sample; legal range ≥1.
- `CNT_WIDTH`, default 8: width of `press_count`.
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `btn_in` input 1: raw button level, asynchronous to `clk`, may bounce.
- `t_out` output 1: registered one-cycle toggle pulse, feeds T of the downstream T flip-flop.
- `btn_stable` output 1: registered debounced button level.
- `busy` output 1: high while a debounce window is in progress.
- `press_count` output `CNT_WIDTH`: number of accepted presses, wraps modulo 2^CNT_WIDTH.

## Operation
- **Synchroniser.** `btn_in` passes through a `SYNC_STAGES`-deep flip-flop chain. The last stage, `sync`, is the only signal the FSM reads.
- **Debounce counter.** `dcnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits and is cleared on every entry to a WAIT state.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - **IDLE** (released): `sync`=1 → PRESS_WAIT, `dcnt`←0; otherwise stay.
  - **PRESS_WAIT:**
    - `sync`=0 → IDLE. The bounce is rejected: no pulse, no count.
    - `sync`=1 and `dcnt`==DEBOUNCE_CYCLES-1 → HELD. Assert `t_out` for one cycle, set `btn_stable`←1, increment `press_count`.
    - Otherwise `dcnt`++.
  - **HELD:** `sync`=0 → RELEASE_WAIT, `dcnt`←0; otherwise stay. No repeat pulses while held, for any hold length.
  - **RELEASE_WAIT:**
    - `sync`=1 → HELD, with no pulse.
    - `sync`=0 and `dcnt`==DEBOUNCE_CYCLES-1 → IDLE, `btn_stable`←0.
    - Otherwise `dcnt`++.
- **Release produces no pulse.** Only a press toggles the downstream flop.
- **`busy`** = (state==PRESS_WAIT) | (state==RELEASE_WAIT), registered with the state.
- **`press_count`** increments by exactly 1 in the same cycle `t_out` is asserted, and wraps from all-ones to 0.
- **`t_out`** is never high in two consecutive cycles.

## Timing
- **Reset values:**
  - synchroniser chain 0
  - state IDLE
  - `dcnt` 0
  - `t_out` 0
  - `btn_stable` 0
  - `busy` 0
  - `press_count` 0
- **Reset asserted mid-debounce or in HELD:** all state is discarded immediately and asynchronously. No pulse is generated.
- **Button held across reset deassertion:** treated as a fresh press after the normal latency, producing one pulse.
- **Press latency.** Edges are counted with edge 1 as the first edge that samples `btn_in`=1. `btn_in` must stay stable high.
  - The FSM enters PRESS_WAIT at edge `SYNC_STAGES`+1.
  - `t_out`, `btn_stable`, and `press_count` update at edge `SYNC_STAGES`+1+`DEBOUNCE_CYCLES`. With defaults, this is edge 7.
  - `t_out` falls at the next edge.
- **Release latency.** `btn_stable` falls at edge `SYNC_STAGES`+1+`DEBOUNCE_CYCLES`, measured the same way from the first sample of `btn_in`=0.
- **Minimum clean press:** `btn_in` must be high for `DEBOUNCE_CYCLES`+1 consecutive synchronised samples. Any low sample restarts from IDLE.
- **Downstream use:** the downstream T flip-flop samples `t_out` at the edge after it is asserted. Q therefore toggles once per accepted press.

## Test plan
- **Reset check:** assert `reset` asynchronously with `btn_in`=1 mid-PRESS_WAIT → all outputs 0 immediately. After release of reset, one pulse at the normal latency. `press_count`=1.
- **Clean press, defaults:** `btn_in` 0→1 held 20 cycles → `t_out`=1 for exactly one cycle after edge 7, `btn_stable`=1 from the same edge, `press_count`=1, `busy` high during edges 3–6.
- **Bouncy press:** `btn_in` toggles 1,0,1,0,1 at 1-cycle spacing, then stays high → exactly one `t_out` pulse, issued `SYNC_STAGES`+1+`DEBOUNCE_CYCLES` edges after the final rising sample. `press_count`=1.
- **Glitch rejection:** `btn_in` high for 3 cycles then low, with defaults → `t_out` never asserts, `press_count`=0, FSM returns to IDLE.
- **Release bounce, then repress:**
  - Press, hold, then a 2-cycle low glitch → no pulse, `btn_stable` stays 1.
  - Full release followed by a second clean press → a second pulse, `press_count`=2.
- **Wrap and downstream check:** `CNT_WIDTH`=2, 5 clean presses → `press_count` sequence 1,2,3,0,1. A T flip-flop connected to `t_out` ends with Q=1.
